memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  Pipeline stage between execute and writeback. Registers execute results and
//  performs data-memory loads/stores over a req/ack handshake. Stalls upstream
//  while an access is outstanding. Its out_* ports drive the writeback stage's
//  in_act_write_res_to_reg, in_instr, in_pc, in_res and in_res_reg_idx.
// PARAMETERS
//  DMEM_ADDR_WIDTH  12   data-memory address width
//  DMEM_WORD_WIDTH  16   data-memory word width (== IALU_WORD_WIDTH)
//  IALU_WORD_WIDTH  16   ALU result / register word width
//  PMEM_WORD_WIDTH  16   instruction word width
//  REG_IDX_WIDTH     4   register index width
//  PC_WIDTH         12   program counter width
//  MAX_WAIT         16   cycles in WAIT without ack before abort (>=2)
// PORTS
//  clock                     in   1    clock; all logic on posedge
//  reset                     in   1    synchronous, active-low; reset==0 at posedge clears all state
//  in_valid                  in   1    execute presents an instruction
//  in_act_load               in   1    instruction is a load
//  in_act_store              in   1    instruction is a store
//  in_act_write_res_to_reg   in   1    result goes to register file
//  in_instr                  in   PMEM_WORD_WIDTH  instruction word
//  in_pc                     in   PC_WIDTH         instruction PC
//  in_res                    in   IALU_WORD_WIDTH  ALU result; memory address for load/store
//  in_store_data             in   IALU_WORD_WIDTH  store data
//  in_res_reg_idx            in   REG_IDX_WIDTH    destination register
//  out_stall                 out  1    upstream must hold inputs
//  dmem_req                  out  1    memory request
//  dmem_we                   out  1    1 = write, 0 = read
//  dmem_addr                 out  DMEM_ADDR_WIDTH  in_res[DMEM_ADDR_WIDTH-1:0]
//  dmem_wdata                out  DMEM_WORD_WIDTH  store data
//  dmem_rdata                in   DMEM_WORD_WIDTH  load data; valid when dmem_ack=1
//  dmem_ack                  in   1    access complete
//  out_act_write_res_to_reg  out  1    to writeback
//  out_instr                 out  PMEM_WORD_WIDTH  to writeback
//  out_pc                    out  PC_WIDTH         to writeback
//  out_res                   out  IALU_WORD_WIDTH  to writeback
//  out_res_reg_idx           out  REG_IDX_WIDTH    to writeback
//  out_mem_error             out  1    sticky: access timed out
// BEHAVIOUR
//  - Reset: state IDLE, wait counter 0. All outputs 0, except out_stall, which is
//    combinational and therefore also 0.
//  - out_stall = (state==WAIT). Inputs are sampled only in IDLE.
//  - IDLE, in_valid=0: the next cycle drives a bubble. All out_* except
//    out_mem_error are 0.
//  - IDLE, in_valid=1, no load/store: out_* are registered from in_* with
//    1-cycle latency. out_res = in_res.
//  - IDLE, in_valid=1, load or store: capture instr, pc, reg_idx, act_write,
//    addr, wdata and kind. Next state is WAIT.
//    - Next cycle: dmem_req=1, dmem_we=store, addr/wdata registered.
//    - A bubble is driven to writeback.
//  - Load and store both set: treated as a load.
//  - WAIT: dmem_req, dmem_we, dmem_addr and dmem_wdata stay stable until ack.
//    - The wait counter increments each cycle with dmem_ack=0.
//    - Outputs to writeback stay a bubble.
//  - WAIT, dmem_ack=1:
//    - Next cycle: load drives out_res=dmem_rdata,
//      out_act_write_res_to_reg=captured act_write, captured instr/pc/idx.
//    - Next cycle: store drives out_act_write_res_to_reg=0 with instr/pc passed.
//    - Next cycle: dmem_req=0, counter=0, state IDLE, stall drops.
//  - WAIT, counter==MAX_WAIT-1, dmem_ack=0:
//    - Abort: out_mem_error<=1 (sticky until reset).
//    - Bubble to writeback (act_write=0, res=0). dmem_req=0. Back to IDLE.
//  - Ack in the timeout cycle: ack wins, no error.
//  - dmem_ack in IDLE is ignored. No back-to-back req: at least one idle cycle
//    separates accesses.
//  - Reset mid-WAIT: the next edge clears req, state, error and outputs. A late
//    ack is ignored.
// TESTING
//  - ALU op: in_valid=1, in_res=16'h1234, idx=3, act_write=1 -> next cycle
//    out_res=16'h1234, out_res_reg_idx=3, out_act_write_res_to_reg=1, out_stall=0.
//  - Load, 2-cycle ack latency: addr 16'h0010, rdata=16'hBEEF -> dmem_req high
//    2 cycles, addr=12'h010, we=0.
//    - out_stall high exactly during WAIT.
//    - out_res=16'hBEEF with act_write=1 the cycle after ack.
//  - Store: addr 16'h0020, data 16'h5A5A, ack after 1 cycle -> dmem_we=1,
//    wdata=16'h5A5A. Writeback sees act_write=0. Stall released after ack.
//  - Timeout: load, never ack, MAX_WAIT=16 -> out_mem_error=1 after 16 WAIT
//    cycles, req drops, bubble output. The following ALU op passes normally.
//  - Ack exactly on cycle MAX_WAIT-1 -> load completes, out_mem_error stays 0.
//  - Reset low during WAIT -> next cycle dmem_req=0, out_stall=0, all outputs 0.
//    An ack asserted afterwards has no effect.

Source files
------------

// File: rtl/memory_access.sv
// memory_access: pipeline stage between execute and writeback.
// Registers execute results and performs data-memory loads/stores over a req/ack handshake.
//
// Ports:
//   clock, reset             clock (posedge); synchronous active-low reset
//   in_*                     instruction from execute, sampled only while idle
//   out_stall                upstream must hold its inputs (access outstanding)
//   dmem_req/we/addr/wdata   data-memory request, held stable until dmem_ack
//   dmem_rdata, dmem_ack     data-memory response
//   out_*                    registered results to writeback
//   out_mem_error            sticky flag: an access timed out
module memory_access #(
  parameter int unsigned DMEM_ADDR_WIDTH = 12,
  parameter int unsigned DMEM_WORD_WIDTH = 16,
  parameter int unsigned IALU_WORD_WIDTH = 16,
  parameter int unsigned PMEM_WORD_WIDTH = 16,
  parameter int unsigned REG_IDX_WIDTH   = 4,
  parameter int unsigned PC_WIDTH        = 12,
  parameter int unsigned MAX_WAIT        = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       in_act_load,
  input  logic                       in_act_store,
  input  logic                       in_act_write_res_to_reg,
  input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [IALU_WORD_WIDTH-1:0] in_res,
  input  logic [IALU_WORD_WIDTH-1:0] in_store_data,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  output logic                       out_stall,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [DMEM_WORD_WIDTH-1:0] dmem_wdata,
  input  logic [DMEM_WORD_WIDTH-1:0] dmem_rdata,
  input  logic                       dmem_ack,
  output logic                       out_act_write_res_to_reg,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
  output logic                       out_mem_error
);

  localparam int unsigned CntW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                     state_q;
  logic [CntW-1:0]            wait_cnt_q;
  logic                       cap_act_q;
  logic [PMEM_WORD_WIDTH-1:0] cap_instr_q;
  logic [PC_WIDTH-1:0]        cap_pc_q;
  logic [REG_IDX_WIDTH-1:0]   cap_idx_q;

  assign out_stall = (state_q == StWait);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q                  <= StIdle;
      wait_cnt_q               <= '0;
      cap_act_q                <= 1'b0;
      cap_instr_q              <= '0;
      cap_pc_q                 <= '0;
      cap_idx_q                <= '0;
      dmem_req                 <= 1'b0;
      dmem_we                  <= 1'b0;
      dmem_addr                <= '0;
      dmem_wdata               <= '0;
      out_act_write_res_to_reg <= 1'b0;
      out_instr                <= '0;
      out_pc                   <= '0;
      out_res                  <= '0;
      out_res_reg_idx          <= '0;
      out_mem_error            <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // Default: bubble to writeback; overwritten for a plain ALU op.
          out_act_write_res_to_reg <= 1'b0;
          out_instr                <= '0;
          out_pc                   <= '0;
          out_res                  <= '0;
          out_res_reg_idx          <= '0;
          if (in_valid && (in_act_load || in_act_store)) begin
            state_q     <= StWait;
            wait_cnt_q  <= '0;
            cap_act_q   <= in_act_write_res_to_reg;
            cap_instr_q <= in_instr;
            cap_pc_q    <= in_pc;
            cap_idx_q   <= in_res_reg_idx;
            dmem_req    <= 1'b1;
            // Load wins when both kinds are flagged; dmem_we doubles as the captured kind.
            dmem_we     <= in_act_store & ~in_act_load;
            dmem_addr   <= in_res[DMEM_ADDR_WIDTH-1:0];
            dmem_wdata  <= in_store_data;
          end else if (in_valid) begin
            out_act_write_res_to_reg <= in_act_write_res_to_reg;
            out_instr                <= in_instr;
            out_pc                   <= in_pc;
            out_res                  <= in_res;
            out_res_reg_idx          <= in_res_reg_idx;
          end
        end
        StWait: begin
          if (dmem_ack) begin
            state_q         <= StIdle;
            wait_cnt_q      <= '0;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            out_instr       <= cap_instr_q;
            out_pc          <= cap_pc_q;
            out_res_reg_idx <= cap_idx_q;
            if (dmem_we) begin
              out_act_write_res_to_reg <= 1'b0;
              out_res                  <= '0;
            end else begin
              out_act_write_res_to_reg <= cap_act_q;
              out_res                  <= dmem_rdata;
            end
          end else if (wait_cnt_q == CntLast) begin
            // Timeout abort: writeback outputs are already a bubble.
            state_q       <= StIdle;
            wait_cnt_q    <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            out_mem_error <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  typedef struct {
    logic        act;
    logic [15:0] instr;
    logic [11:0] pc;
    logic [15:0] res;
    logic [3:0]  idx;
    logic        chk_data;  // 0: res/idx not compared (store completion)
  } wb_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_act_load = 1'b0, in_act_store = 1'b0;
  logic        in_act_write_res_to_reg = 1'b0;
  logic [15:0] in_instr = '0;
  logic [11:0] in_pc = '0;
  logic [15:0] in_res = '0, in_store_data = '0;
  logic [3:0]  in_res_reg_idx = '0;
  logic        out_stall, dmem_req, dmem_we;
  logic [11:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        out_act_write_res_to_reg;
  logic [15:0] out_instr;
  logic [11:0] out_pc;
  logic [15:0] out_res;
  logic [3:0]  out_res_reg_idx;
  logic        out_mem_error;

  int n_assert = 0;
  int n_fail   = 0;
  wb_t sb[$];

  memory_access dut (
    .clock                    (clock),
    .reset                    (reset),
    .in_valid                 (in_valid),
    .in_act_load              (in_act_load),
    .in_act_store             (in_act_store),
    .in_act_write_res_to_reg  (in_act_write_res_to_reg),
    .in_instr                 (in_instr),
    .in_pc                    (in_pc),
    .in_res                   (in_res),
    .in_store_data            (in_store_data),
    .in_res_reg_idx           (in_res_reg_idx),
    .out_stall                (out_stall),
    .dmem_req                 (dmem_req),
    .dmem_we                  (dmem_we),
    .dmem_addr                (dmem_addr),
    .dmem_wdata               (dmem_wdata),
    .dmem_rdata               (dmem_rdata),
    .dmem_ack                 (dmem_ack),
    .out_act_write_res_to_reg (out_act_write_res_to_reg),
    .out_instr                (out_instr),
    .out_pc                   (out_pc),
    .out_res                  (out_res),
    .out_res_reg_idx          (out_res_reg_idx),
    .out_mem_error            (out_mem_error)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic act,
                       input logic [15:0] instr, input logic [11:0] pc, input logic [15:0] res,
                       input logic [15:0] sd, input logic [3:0] idx);
    in_valid = v; in_act_load = ld; in_act_store = st; in_act_write_res_to_reg = act;
    in_instr = instr; in_pc = pc; in_res = res; in_store_data = sd; in_res_reg_idx = idx;
  endtask

  task automatic push(input logic act, input logic [15:0] instr, input logic [11:0] pc,
                      input logic [15:0] res, input logic [3:0] idx, input logic cd);
    wb_t e;
    e.act = act; e.instr = instr; e.pc = pc; e.res = res; e.idx = idx; e.chk_data = cd;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    push(1'b0, 16'h0, 12'h0, 16'h0, 4'h0, 1'b1);
  endtask

  task automatic check_wb(input string tag);
    wb_t e;
    n_assert++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_act"}, 32'(out_act_write_res_to_reg), 32'(e.act));
      chk({tag, "_instr"}, 32'(out_instr), 32'(e.instr));
      chk({tag, "_pc"}, 32'(out_pc), 32'(e.pc));
      if (e.chk_data) begin
        chk({tag, "_res"}, 32'(out_res), 32'(e.res));
        chk({tag, "_idx"}, 32'(out_res_reg_idx), 32'(e.idx));
      end
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    step();
    step();
    push_bubble();
    check_wb("rst");
    chk("rst_stall", 32'(out_stall), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", 32'(dmem_addr), 32'd0);
    chk("rst_err", 32'(out_mem_error), 32'd0);
    reset = 1'b1;

    // ALU op passes through with one cycle latency
    drive(1, 0, 0, 1, 16'hA001, 12'h004, 16'h1234, 16'h0, 4'd3);
    push(1'b1, 16'hA001, 12'h004, 16'h1234, 4'd3, 1'b1);
    step();
    check_wb("alu");
    chk("alu_stall", 32'(out_stall), 32'd0);
    chk("alu_req", 32'(dmem_req), 32'd0);

    // Load with ack in the second WAIT cycle
    drive(1, 1, 0, 1, 16'hB002, 12'h008, 16'h0010, 16'h0, 4'd5);
    push_bubble();
    step();
    check_wb("ld_issue");
    chk("ld_req1", 32'(dmem_req), 32'd1);
    chk("ld_we", 32'(dmem_we), 32'd0);
    chk("ld_addr", 32'(dmem_addr), 32'h010);
    chk("ld_stall1", 32'(out_stall), 32'd1);
    push_bubble();
    step();
    check_wb("ld_wait");
    chk("ld_req2", 32'(dmem_req), 32'd1);
    chk("ld_stall2", 32'(out_stall), 32'd1);
    dmem_ack = 1'b1;
    dmem_rdata = 16'hBEEF;
    push(1'b1, 16'hB002, 12'h008, 16'hBEEF, 4'd5, 1'b1);
    step();
    check_wb("ld_done");
    chk("ld_req_drop", 32'(dmem_req), 32'd0);
    chk("ld_stall_drop", 32'(out_stall), 32'd0);
    dmem_ack = 1'b0;

    // Idle bubble; an ack in IDLE must be ignored
    drive(0, 0, 0, 0, 16'h0, 12'h0, 16'h0, 16'h0, 4'd0);
    dmem_ack = 1'b1;
    push_bubble();
    step();
    check_wb("bubble");
    chk("idle_ack_req", 32'(dmem_req), 32'd0);
    chk("idle_ack_stall", 32'(out_stall), 32'd0);
    dmem_ack = 1'b0;

    // Store, ack after one cycle; writeback sees no register write
    drive(1, 0, 1, 1, 16'hC003, 12'h00C, 16'h0020, 16'h5A5A, 4'd6);
    push_bubble();
    step();
    check_wb("st_issue");
    chk("st_req", 32'(dmem_req), 32'd1);
    chk("st_we", 32'(dmem_we), 32'd1);
    chk("st_addr", 32'(dmem_addr), 32'h020);
    chk("st_wdata", 32'(dmem_wdata), 32'h5A5A);
    chk("st_stall", 32'(out_stall), 32'd1);
    dmem_ack = 1'b1;
    push(1'b0, 16'hC003, 12'h00C, 16'h0, 4'd0, 1'b0);
    step();
    check_wb("st_done");
    chk("st_stall_drop", 32'(out_stall), 32'd0);
    chk("st_req_drop", 32'(dmem_req), 32'd0);
    dmem_ack = 1'b0;

    // Timeout: load never acked, abort after 16 WAIT cycles
    drive(1, 1, 0, 1, 16'hD010, 12'h018, 16'h0030, 16'h0, 4'd1);
    push_bubble();
    step();
    check_wb("to_issue");
    for (int i = 0; i < 15; i++) begin
      push_bubble();
      step();
      check_wb("to_wait");
      chk("to_wait_req", 32'(dmem_req), 32'd1);
      chk("to_wait_stall", 32'(out_stall), 32'd1);
      chk("to_wait_err", 32'(out_mem_error), 32'd0);
    end
    push_bubble();
    step();
    check_wb("to_abort");
    chk("to_err", 32'(out_mem_error), 32'd1);
    chk("to_req", 32'(dmem_req), 32'd0);
    chk("to_stall", 32'(out_stall), 32'd0);
    drive(1, 0, 0, 1, 16'hD004, 12'h010, 16'h7777, 16'h0, 4'd2);
    push(1'b1, 16'hD004, 12'h010, 16'h7777, 4'd2, 1'b1);
    step();
    check_wb("to_alu");
    chk("to_err_sticky", 32'(out_mem_error), 32'd1);

    // Reset clears the sticky error
    reset = 1'b0;
    step();
    chk("rst_err_clr", 32'(out_mem_error), 32'd0);
    reset = 1'b1;

    // Ack on the last allowed cycle; load+store flagged together acts as a load
    drive(1, 1, 1, 1, 16'hE005, 12'h014, 16'h0040, 16'h1111, 4'd7);
    push_bubble();
    step();
    check_wb("late_issue");
    chk("late_we", 32'(dmem_we), 32'd0);
    chk("late_addr", 32'(dmem_addr), 32'h040);
    for (int i = 0; i < 15; i++) begin
      push_bubble();
      step();
      check_wb("late_wait");
      chk("late_wait_req", 32'(dmem_req), 32'd1);
    end
    dmem_ack = 1'b1;
    dmem_rdata = 16'hCAFE;
    push(1'b1, 16'hE005, 12'h014, 16'hCAFE, 4'd7, 1'b1);
    step();
    check_wb("late_done");
    chk("late_err", 32'(out_mem_error), 32'd0);
    chk("late_req", 32'(dmem_req), 32'd0);
    chk("late_stall", 32'(out_stall), 32'd0);
    dmem_ack = 1'b0;

    // Reset during WAIT, then a stray ack
    drive(1, 1, 0, 1, 16'hF006, 12'h01C, 16'h0050, 16'h0, 4'd8);
    push_bubble();
    step();
    check_wb("rw_issue");
    chk("rw_req", 32'(dmem_req), 32'd1);
    reset = 1'b0;
    push_bubble();
    step();
    check_wb("rw_rst");
    chk("rw_rst_req", 32'(dmem_req), 32'd0);
    chk("rw_rst_stall", 32'(out_stall), 32'd0);
    chk("rw_rst_addr", 32'(dmem_addr), 32'd0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 16'h0, 12'h0, 16'h0, 16'h0, 4'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 16'hDEAD;
    push_bubble();
    step();
    check_wb("rw_late_ack");
    chk("rw_late_req", 32'(dmem_req), 32'd0);
    chk("rw_late_stall", 32'(out_stall), 32'd0);
    chk("rw_late_err", 32'(out_mem_error), 32'd0);
    dmem_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
